dcache_direct_wb: RTL and testbench
===================================

Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline's D-port (D_read/D_write/D_addr/D_wdata/D_stall/D_rdata) and the 128-bit-line main memory.
- Serves hits with zero stall.
- On a miss it holds proc_stall high, writes back a dirty victim line if needed, fetches the new line, then serves the request.
- The same block, with writes never issued, also serves as the I-cache.

Parameters:
- INDEX_W, 3: index bits; number of lines = 2**INDEX_W. Line size is fixed at 4 words.
- TAG_W, 30-INDEX_W-2 (derived, not overridable): tag bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- proc_reset  in  1  asynchronous, active-high reset
- proc_read  in  1  processor read request
- proc_write  in  1  processor write request
- proc_addr  in  30  word address: [1:0] offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag
- proc_wdata  in  32  write data
- proc_rdata  out  32  read data, valid when proc_read=1 and proc_stall=0
- proc_stall  out  1  request not yet complete; processor holds request stable
- mem_read  out  1  line fetch request
- mem_write  out  1  line write-back request
- mem_addr  out  28  line address
- mem_wdata  out  128  victim line; word n at bits [32n+31:32n]
- mem_rdata  in  128  fetched line, same word order
- mem_ready  in  1  one-cycle completion pulse from memory

Behaviour:
- Storage per line: valid, dirty, tag, 4x32 data. Registers only, no SRAM macro.
- Reset: all valid/dirty/tag/data cleared, state=IDLE.
- Reset is asynchronous: mem_read=0, mem_write=0 and proc_stall=0 take effect immediately, not at the next edge.
- After reset, proc_rdata=0 for any address until a line is filled.
- Outputs are Moore-decoded from state plus the array contents, except proc_stall and proc_rdata, which are combinational on the request in IDLE.
- hit = valid[idx] & (tag[idx]==addr_tag). req = proc_read|proc_write.
- proc_write has priority when both request lines are high (illegal case; the request is treated as a write).
- State IDLE:
  - no req: proc_stall=0, no state change.
  - read hit: proc_rdata = data[idx][off] in the same cycle, proc_stall=0.
  - write hit: proc_stall=0; at the edge, data[idx][off]<=proc_wdata and dirty[idx]<=1.
  - miss with valid&dirty victim: proc_stall=1, next state WRITEBACK.
  - miss otherwise: proc_stall=1, next state ALLOCATE.
- State WRITEBACK:
  - mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx], proc_stall=1.
  - Held until mem_ready=1; then next state ALLOCATE and dirty[idx]<=0.
- State ALLOCATE:
  - mem_read=1, mem_addr=proc_addr[29:2], proc_stall=1.
  - On mem_ready=1: data[idx]<=mem_rdata, tag[idx]<=addr_tag, valid<=1, dirty<=0, next state IDLE.
  - The request then hits in IDLE and completes there, including a write merge.
- Never both mem_read and mem_write high. mem_ready is ignored in IDLE.
- Latency:
  - hit: 0 stall cycles.
  - clean miss: 1 (IDLE detect) + ALLOCATE cycles up to and including mem_ready; stall drops the cycle after the fill.
  - dirty miss: adds the WRITEBACK cycles.
- mem_ready arriving in the first cycle of WRITEBACK/ALLOCATE is legal and advances the state.
- Reset mid-miss: state returns to IDLE, all lines invalid; dirty data is discarded and in-flight memory transactions are abandoned.
- The processor must keep proc_addr/proc_wdata/request stable while proc_stall=1; behaviour otherwise is undefined.

Test Plan:
1. Reset, then proc_read addr 0x0000000: proc_stall=1, next cycle mem_read=1 mem_addr=0. Memory pulses mem_ready at cycle 4 with mem_rdata={W3..W0}={4,3,2,1}. Required: mem_read drops, next cycle proc_stall=0 proc_rdata=1.
2. Read addr 0x0000002 immediately after: proc_stall=0 in the same cycle, proc_rdata=3, mem_read stays 0.
3. Write addr 0x0000001 data 0xDEADBEEF: no stall, mem idle. Then read addr 0x0000001 -> proc_rdata=0xDEADBEEF.
4. Read addr 0x0000020 (index 0, tag 1; conflicts with the dirty line):
   - WRITEBACK first: mem_write=1 mem_addr=0 mem_wdata={4,3,0xDEADBEEF,1}.
   - After mem_ready: mem_read=1 mem_addr=8.
   - Fill {8,7,6,5} -> proc_rdata=5.
5. Assert proc_reset during ALLOCATE: mem_read=0 asynchronously. After release, read addr 0x0000020 misses again (mem_read=1 mem_addr=8).
6. In IDLE with no request, pulse mem_ready and toggle mem_rdata: state, arrays and outputs unchanged; mem_read=mem_write=0, proc_stall=0.

Source files
------------

// File: rtl/dcache_direct_wb.sv
// ============================================================================
// dcache_direct_wb : direct-mapped, write-back, write-allocate cache, 4-word lines
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_direct_wb #(
  parameter int INDEX_W = 3
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int TAG_W = 30 - INDEX_W - 2;
  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]         r_state;
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [127:0]       r_data [LINES];

  logic [1:0]         w_off;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [127:0]       w_line;
  logic               w_req;
  logic               w_hit;
  logic               w_victim_dirty;
  logic               w_stall;

  assign w_off          = proc_addr[1:0];
  assign w_idx          = proc_addr[INDEX_W+1:2];
  assign w_tag          = proc_addr[29:INDEX_W+2];
  assign w_line         = r_data[w_idx];
  assign w_req          = proc_read | proc_write;
  assign w_hit          = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

  // Read data always reflects the addressed word; cleared arrays give 0 after reset.
  assign proc_rdata = w_line[{w_off, 5'd0} +: 32];

  // Stall is forced low while reset is asserted so it drops without waiting for a clock.
  assign proc_stall = w_stall & ~proc_reset;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_req & ~w_hit;
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx};
        mem_wdata = w_line;
        w_stall   = 1'b1;
      end
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = proc_addr[29:2];
        w_stall  = 1'b1;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              // Write wins when both request lines are high.
              if (proc_write) begin
                r_data[w_idx][{w_off, 5'd0} +: 32] <= proc_wdata;
                r_dirty[w_idx]                     <= 1'b1;
              end
            end else if (w_victim_dirty) begin
              r_state <= S_WRITEBACK;
            end else begin
              r_state <= S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          // After the fill the request hits in IDLE, which also merges a pending write.
          if (mem_ready) begin
            r_data[w_idx]  <= mem_rdata;
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_direct_wb.sv
// ============================================================================
// tb_dcache_direct_wb : directed and random checks of dcache_direct_wb against a flat-memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dcache_direct_wb;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int checks   = 0;
  int failures = 0;

  // Main memory contents (line granularity) and the processor's view of memory (word granularity).
  logic [127:0] mem_store [logic [27:0]];
  logic [31:0]  flat      [logic [29:0]];
  // Which line each cache slot holds, as seen from the outside.
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];

  dcache_direct_wb dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    logic [1:0]   n2;
    if (mem_store.exists(la)) return mem_store[la];
    for (int n = 0; n < 4; n++) begin
      n2 = n[1:0];
      l[n*32 +: 32] = {2'b00, la, n2} ^ 32'h5A00_0000;
    end
    return l;
  endfunction

  function automatic logic [31:0] flat_get(input logic [29:0] w);
    logic [127:0] l;
    if (flat.exists(w)) return flat[w];
    l = mem_line(w[29:2]);
    return l[{w[1:0], 5'd0} +: 32];
  endfunction

  function automatic logic [127:0] line_view(input logic [27:0] la);
    logic [127:0] l;
    logic [1:0]   n2;
    for (int n = 0; n < 4; n++) begin
      n2 = n[1:0];
      l[n*32 +: 32] = flat_get({la, n2});
    end
    return l;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    flat.delete();
  endtask

  // Issues one request (caller is just past a rising edge) and acts as main memory until it completes.
  task automatic access(input bit wr, input bit both, input logic [29:0] a, input logic [31:0] wd,
                        input int lat_wb, input int lat_al, output logic [31:0] rd);
    int          idx;
    bit          hit;
    bit          wb;
    bit          done;
    bit          wb_seen;
    int          exp_stall;
    int          stall_cnt;
    int          wb_cnt;
    int          al_cnt;
    int          cyc;
    logic [27:0] vla;
    logic [27:0] ma;
    idx       = int'(a[4:2]);
    hit       = m_valid[idx] && (m_tag[idx] == a[29:5]);
    wb        = !hit && m_valid[idx] && m_dirty[idx];
    vla       = {m_tag[idx], a[4:2]};
    exp_stall = hit ? 0 : (1 + (wb ? lat_wb : 0) + lat_al);
    done = 0; wb_seen = 0; stall_cnt = 0; wb_cnt = 0; al_cnt = 0; cyc = 0; rd = '0;
    proc_read  = !wr || both;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (!proc_stall) begin
        chk("mem_idle_at_completion", 128'({mem_read, mem_write}), 128'(2'b00));
        rd = proc_rdata;
        if (!wr) chk("read_data", 128'(proc_rdata), 128'(flat_get(a)));
        done = 1;
      end else begin
        stall_cnt++;
        if (mem_write) begin
          if (wb_cnt == 0) begin
            wb_seen = 1;
            chk("wb_addr", 128'(mem_addr), 128'(vla));
            chk("wb_data", mem_wdata, line_view(vla));
          end
          wb_cnt++;
          if (wb_cnt == lat_wb) begin
            ma = mem_addr;
            mem_store[ma] = mem_wdata;
            mem_ready = 1'b1;
          end
        end else if (mem_read) begin
          if (al_cnt == 0) chk("fill_addr", 128'(mem_addr), 128'(a[29:2]));
          al_cnt++;
          if (al_cnt == lat_al) begin
            mem_rdata = mem_line(a[29:2]);
            mem_ready = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      cyc++;
    end
    chk("completed_within_budget", 128'(done), 128'(1'b1));
    chk("stall_cycles", 128'(stall_cnt), 128'(exp_stall));
    chk("writeback_occurred", 128'(wb_seen), 128'(wb));
    proc_read  = 1'b0;
    proc_write = 1'b0;
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[29:5];
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      flat[a]      = wd;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [29:0] a;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'h7;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    mem_store[28'h0] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_store[28'h8] = {32'd8, 32'd7, 32'd6, 32'd5};
    model_reset();

    #12;
    chk("reset_mem_read", 128'(mem_read), 128'(1'b0));
    chk("reset_mem_write", 128'(mem_write), 128'(1'b0));
    chk("reset_stall", 128'(proc_stall), 128'(1'b0));
    chk("reset_rdata", 128'(proc_rdata), 128'(32'h0));
    @(posedge clk);
    #1;
    proc_reset = 1'b0;

    // Cold read miss, then hits and a write merge on the resident line.
    access(1'b0, 1'b0, 30'h0, 32'h0, 1, 3, rd);
    chk("t1_rdata", 128'(rd), 128'(32'd1));
    access(1'b0, 1'b0, 30'h2, 32'h0, 1, 1, rd);
    chk("t2_rdata", 128'(rd), 128'(32'd3));
    access(1'b1, 1'b0, 30'h1, 32'hDEADBEEF, 1, 1, rd);
    access(1'b0, 1'b0, 30'h1, 32'h0, 1, 1, rd);
    chk("t3_rdata", 128'(rd), 128'(32'hDEADBEEF));

    // Conflict miss on a dirty line: write-back then fill.
    access(1'b0, 1'b0, 30'h20, 32'h0, 2, 2, rd);
    chk("t4_rdata", 128'(rd), 128'(32'd5));
    chk("t4_mem_written_back", mem_store[28'h0], {32'd4, 32'd3, 32'hDEADBEEF, 32'd1});

    // Reset in the middle of a fill.
    proc_addr = 30'h40;
    proc_read = 1'b1;
    @(negedge clk);
    chk("t5_detect_stall", 128'(proc_stall), 128'(1'b1));
    chk("t5_detect_no_mem", 128'(mem_read), 128'(1'b0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_alloc_read", 128'(mem_read), 128'(1'b1));
    chk("t5_alloc_addr", 128'(mem_addr), 128'(28'h10));
    #2;
    proc_reset = 1'b1;
    #1;
    chk("t5_async_mem_read", 128'(mem_read), 128'(1'b0));
    chk("t5_async_mem_write", 128'(mem_write), 128'(1'b0));
    chk("t5_async_stall", 128'(proc_stall), 128'(1'b0));
    chk("t5_cleared_rdata", 128'(proc_rdata), 128'(32'h0));
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_reset = 1'b0;
    model_reset();
    access(1'b0, 1'b0, 30'h20, 32'h0, 1, 2, rd);
    chk("t5_refill_rdata", 128'(rd), 128'(32'd5));

    // Stray memory responses while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = 1'b1;
      @(negedge clk);
      chk("t6_idle_mem_read", 128'(mem_read), 128'(1'b0));
      chk("t6_idle_mem_write", 128'(mem_write), 128'(1'b0));
      chk("t6_idle_stall", 128'(proc_stall), 128'(1'b0));
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    access(1'b0, 1'b0, 30'h22, 32'h0, 1, 1, rd);
    chk("t6_line_intact", 128'(rd), 128'(32'd7));

    // Random traffic over a few tags per index to force hits, clean and dirty misses.
    for (int k = 0; k < 300; k++) begin
      logic [24:0] tg;
      logic [2:0]  ix;
      logic [1:0]  of;
      bit          wr;
      tg = 25'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      of = 2'($urandom_range(0, 3));
      a  = {tg, ix, of};
      wr = bit'($urandom_range(0, 1));
      access(wr, wr && ($urandom_range(0, 3) == 0), a, $urandom,
             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
